filter_pair_arbiter: RTL and testbench
======================================

Name: filter_pair_arbiter

Overview:
- Read side of the filter buffers: sits between NUM_FILTER filter instances in a filter bank and one force pipeline.
- Selects round-robin among filters reporting a pair available and pulses that filter's read select.
- Captures the popped record {ref_id, neighbor_id, r2, dz, dy, dx} one cycle later and presents it to the force pipeline with a valid/ready handshake.
- Never reads an empty buffer; never drops or duplicates a pair.

Parameters:
- DATA_WIDTH, 32, width of r2/dx/dy/dz (IEEE single).
- PARTICLE_ID_WIDTH, 20, width of each particle ID.
- NUM_FILTER, 4, number of filters served (2..16).
- PAIR_WIDTH, 2*PARTICLE_ID_WIDTH+4*DATA_WIDTH, one buffer record (derived, not overridden).

Ports:
- clk  in  1  single clock.
- rst  in  1  asynchronous, active-low reset.
- filter_available  in  NUM_FILTER  bit i = filter i buffer non-empty.
- filter_sel  out  NUM_FILTER  one-hot-or-zero read request; bit i drives filter i sel.
- filter_data  in  NUM_FILTER*PAIR_WIDTH  filter i record at [i*PAIR_WIDTH +: PAIR_WIDTH]; MSB-LSB {ref_id, neighbor_id, r2, dz, dy, dx}.
- out_ready  in  1  force pipeline accepts this cycle.
- out_valid  out  1  output record valid.
- ref_particle_id_out  out  PARTICLE_ID_WIDTH.
- neighbor_particle_id_out  out  PARTICLE_ID_WIDTH.
- r2, dx, dy, dz  out  DATA_WIDTH each.

Behaviour:
- Reset (rst=0, async): out_valid=0, all data outputs 0, filter_sel=0, rr pointer=0, in-flight flag=0, skid occupancy=0. filter_sel is also forced to 0 combinationally while rst=0.
- Buffer read latency is fixed at 1 cycle: record for a sel asserted in cycle t is sampled from filter_data in cycle t+1.
- Grant logic:
  - filter_sel is combinational from the rr pointer, filter_available and can_issue.
  - The grant is the first available filter at or after the pointer, wrapping modulo NUM_FILTER.
  - On a grant to filter k, the pointer becomes (k+1) mod NUM_FILTER.
  - With no grant, the pointer holds.
- Pipeline stages:
  - S0 grant: registered grant_idx and inflight=1.
  - S1 capture: data mux by grant_idx; push into 2-entry skid FIFO.
  - Output: head of skid.
- Throughput control:
  - can_issue = (occ + inflight - pop) <= 1, where pop = out_valid & out_ready.
  - Sustains 1 pair/cycle with out_ready held high.
  - Guarantees a captured record always has a free skid slot.
- Latency: sel cycle t -> out_valid at t+2 when skid empty.
- Handshake:
  - out_valid stays high and data stays stable until out_ready.
  - out_ready with out_valid=0 has no effect.
  - out_valid is independent of out_ready (no combinational path ready->valid).
- Boundary conditions:
  - Simultaneous push and pop: occupancy unchanged, order preserved.
  - All filter_available=0: sel=0 and pointer holds.
  - Only one filter available for consecutive cycles: re-granted every cycle, since available is a registered buffer flag updated at the read edge.
  - out_ready low with occ=2: no further sel.
  - Reset mid-operation: in-flight and skid contents are discarded. The filters must be reset together with this block.

Optional Feature:
- ARB_PERF_COUNTER_EN
- Defined:
  - Adds output pair_count [31:0]: increments on each pop, wraps at 2^32, reset 0.
  - Adds output stall_count [31:0]: increments each cycle with any filter_available=1 and can_issue=0, saturates at 32'hFFFFFFFF, reset 0.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Shared package: PAIR_WIDTH and field offsets/widths for ref_id, neighbor_id, r2, dz, dy, dx. The filter logic and the force pipeline use the same constants.
- One sub-module, filter_rr_grant:
  - Inputs: request vector, pointer.
  - Outputs: one-hot grant, grant index, next pointer.
  - Combinational and parameterised by NUM_FILTER.

Test Plan:
1. Reset: rst=0 with filter_available=4'b1111 -> filter_sel=0, out_valid=0, all outputs 0. Release -> first sel=4'b0001.
2. Round robin: all available, out_ready=1 -> sel sequence 0001,0010,0100,1000,0001. out_valid continuous from cycle 2; each record matches the filter_data presented for that filter.
3. Sparse requests: available=4'b1010, pointer=0 -> grant 4'b0010, pointer=2 -> next grant 4'b1000. Available=0 -> sel=0 and pointer held.
4. Backpressure: out_ready=0 for 10 cycles with all available -> exactly 2 sels issued, out_valid=1, data frozen. out_ready=1 -> two records drained in order, then issue resumes at 1/cycle.
5. Data integrity: filter 2 feeds ref=20'h00123, nbr=20'h00456, r2=32'h42C80000, dz/dy/dx distinct -> identical fields on outputs; no duplicates or losses over 1000 random available/ready cycles (scoreboard).
6. ARB_PERF_COUNTER_EN defined: 100 pops -> pair_count=100. 5 blocked-request cycles -> stall_count=5.

Source files
------------

// File: rtl/filter_pair_arbiter_pkg.sv
// Pair-record layout shared by the filters, this arbiter and the force pipeline.
// Record MSB..LSB: {ref_id, neighbor_id, r2, dz, dy, dx}.
package filter_pair_arbiter_pkg;
  localparam int FP_DATA_WIDTH = 32;
  localparam int FP_ID_WIDTH   = 20;

  // Float fields sit in the low part of the record, in DATA_WIDTH-sized slots.
  localparam int DX_SLOT = 0;
  localparam int DY_SLOT = 1;
  localparam int DZ_SLOT = 2;
  localparam int R2_SLOT = 3;

  function automatic int pair_width(input int dw, input int idw);
    return 2*idw + 4*dw;
  endfunction

  function automatic int nbr_lsb(input int dw);
    return 4*dw;
  endfunction

  function automatic int ref_lsb(input int dw, input int idw);
    return 4*dw + idw;
  endfunction

  localparam int FP_PAIR_WIDTH = pair_width(FP_DATA_WIDTH, FP_ID_WIDTH);
endpackage

// File: rtl/filter_rr_grant.sv
// Combinational round-robin pick: first request at or after ptr, wrapping.
module filter_rr_grant #(
  parameter  int NUM_FILTER = 4,
  localparam int PW = $clog2(NUM_FILTER)
) (
  input  logic [NUM_FILTER-1:0] req,
  input  logic [PW-1:0]         ptr,
  output logic [NUM_FILTER-1:0] grant,
  output logic [PW-1:0]         grant_idx,
  output logic [PW-1:0]         next_ptr
);
  localparam logic [PW:0] N_W = (PW+1)'(NUM_FILTER);

  logic [2*NUM_FILTER-1:0] req2;
  logic [NUM_FILTER-1:0]   rot;
  logic [PW-1:0]           off;
  logic [PW:0]             idx_w, nxt_w;
  logic                    found;

  always_comb begin
    req2  = {req, req};
    rot   = req2[{1'b0, ptr} +: NUM_FILTER];
    found = 1'b0;
    off   = '0;
    for (int i = NUM_FILTER-1; i >= 0; i--) begin
      if (rot[i]) begin
        found = 1'b1;
        off   = PW'(i);
      end
    end
    idx_w = {1'b0, ptr} + {1'b0, off};
    if (idx_w >= N_W) idx_w = idx_w - N_W;
    nxt_w = idx_w + (PW+1)'(1);
    if (nxt_w == N_W) nxt_w = '0;
    grant_idx = idx_w[PW-1:0];
    grant     = found ? (NUM_FILTER'(1) << grant_idx) : '0;
    next_ptr  = found ? nxt_w[PW-1:0] : ptr;
  end
endmodule

// File: rtl/filter_pair_arbiter.sv
// Round-robin reader of NUM_FILTER pair buffers feeding one force pipeline
// through a 2-entry skid FIFO. Optional perf counters: ARB_PERF_COUNTER_EN.
module filter_pair_arbiter
  import filter_pair_arbiter_pkg::*;
#(
  parameter  int DATA_WIDTH        = FP_DATA_WIDTH,
  parameter  int PARTICLE_ID_WIDTH = FP_ID_WIDTH,
  parameter  int NUM_FILTER        = 4,
  localparam int PAIR_WIDTH        = pair_width(DATA_WIDTH, PARTICLE_ID_WIDTH)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_FILTER-1:0]            filter_available,
  output logic [NUM_FILTER-1:0]            filter_sel,
  input  logic [NUM_FILTER*PAIR_WIDTH-1:0] filter_data,
  input  logic                             out_ready,
  output logic                             out_valid,
  output logic [PARTICLE_ID_WIDTH-1:0]     ref_particle_id_out,
  output logic [PARTICLE_ID_WIDTH-1:0]     neighbor_particle_id_out,
  output logic [DATA_WIDTH-1:0]            r2,
  output logic [DATA_WIDTH-1:0]            dx,
  output logic [DATA_WIDTH-1:0]            dy,
  output logic [DATA_WIDTH-1:0]            dz
`ifdef ARB_PERF_COUNTER_EN
  ,
  output logic [31:0]                      pair_count,
  output logic [31:0]                      stall_count
`endif
);
  localparam int PTR_W   = $clog2(NUM_FILTER);
  localparam int NBR_LSB = nbr_lsb(DATA_WIDTH);
  localparam int REF_LSB = ref_lsb(DATA_WIDTH, PARTICLE_ID_WIDTH);

  logic [PTR_W-1:0]      ptr_q, ptr_d, grant_idx_q, grant_idx_d, rr_idx, rr_next;
  logic                  inflight_q, inflight_d;
  logic [1:0]            occ_q, occ_d;
  logic [PAIR_WIDTH-1:0] skid0_q, skid0_d, skid1_q, skid1_d, cap;
  logic [NUM_FILTER-1:0] req, rr_grant;
  logic [PAIR_WIDTH-1:0] fdata [NUM_FILTER];
  logic                  pop, push, can_issue;
  logic [2:0]            load;

  for (genvar i = 0; i < NUM_FILTER; i++) begin : g_unpack
    assign fdata[i] = filter_data[i*PAIR_WIDTH +: PAIR_WIDTH];
  end

  filter_rr_grant #(.NUM_FILTER(NUM_FILTER)) u_rr (
    .req       (req),
    .ptr       (ptr_q),
    .grant     (rr_grant),
    .grant_idx (rr_idx),
    .next_ptr  (rr_next)
  );

  always_comb begin
    pop  = (occ_q != 2'd0) && out_ready;
    push = inflight_q;
    // Issue only if the record it produces is guaranteed a skid slot next cycle.
    load        = 3'(occ_q) + 3'(inflight_q) - 3'(pop);
    can_issue   = (load <= 3'd1);
    req         = can_issue ? filter_available : '0;
    filter_sel  = rst ? rr_grant : '0;
    ptr_d       = rr_next;
    inflight_d  = |rr_grant;
    grant_idx_d = inflight_d ? rr_idx : grant_idx_q;
    cap         = fdata[grant_idx_q];

    skid0_d = skid0_q;
    skid1_d = skid1_q;
    occ_d   = occ_q;
    case ({push, pop})
      2'b10: begin
        if (occ_q == 2'd0) skid0_d = cap;
        else               skid1_d = cap;
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        skid0_d = skid1_q;
        occ_d   = occ_q - 2'd1;
      end
      2'b11: begin
        if (occ_q == 2'd1) skid0_d = cap;
        else begin
          skid0_d = skid1_q;
          skid1_d = cap;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q       <= '0;
      grant_idx_q <= '0;
      inflight_q  <= 1'b0;
      occ_q       <= 2'd0;
      skid0_q     <= '0;
      skid1_q     <= '0;
    end else begin
      ptr_q       <= ptr_d;
      grant_idx_q <= grant_idx_d;
      inflight_q  <= inflight_d;
      occ_q       <= occ_d;
      skid0_q     <= skid0_d;
      skid1_q     <= skid1_d;
    end
  end

  assign out_valid                = (occ_q != 2'd0);
  assign dx                       = skid0_q[DX_SLOT*DATA_WIDTH +: DATA_WIDTH];
  assign dy                       = skid0_q[DY_SLOT*DATA_WIDTH +: DATA_WIDTH];
  assign dz                       = skid0_q[DZ_SLOT*DATA_WIDTH +: DATA_WIDTH];
  assign r2                       = skid0_q[R2_SLOT*DATA_WIDTH +: DATA_WIDTH];
  assign neighbor_particle_id_out = skid0_q[NBR_LSB +: PARTICLE_ID_WIDTH];
  assign ref_particle_id_out      = skid0_q[REF_LSB +: PARTICLE_ID_WIDTH];

`ifdef ARB_PERF_COUNTER_EN
  logic [31:0] pair_count_q, pair_count_d, stall_count_q, stall_count_d;

  always_comb begin
    pair_count_d  = pair_count_q + 32'(pop);
    stall_count_d = stall_count_q;
    if ((|filter_available) && !can_issue && (stall_count_q != 32'hFFFF_FFFF))
      stall_count_d = stall_count_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pair_count_q  <= '0;
      stall_count_q <= '0;
    end else begin
      pair_count_q  <= pair_count_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign pair_count  = pair_count_q;
  assign stall_count = stall_count_q;
`endif
endmodule

// File: tb/tb_filter_pair_arbiter.sv
// Scoreboard bench: filter buffers modelled as queues, expected records queued
// on every read select, a negedge monitor checks grants, latency and data.
module tb_filter_pair_arbiter;
  import filter_pair_arbiter_pkg::*;

  localparam int NF = 4;
  localparam int DW = FP_DATA_WIDTH;
  localparam int IW = FP_ID_WIDTH;
  localparam int PW = FP_PAIR_WIDTH;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [NF-1:0]   filter_available = '0;
  logic [NF-1:0]   filter_sel;
  logic [NF*PW-1:0] filter_data = '0;
  logic            out_ready = 1'b0;
  logic            out_valid;
  logic [IW-1:0]   ref_id, nbr_id;
  logic [DW-1:0]   r2, dx, dy, dz;
`ifdef ARB_PERF_COUNTER_EN
  logic [31:0]     pair_count, stall_count;
`endif

  always #5 clk = ~clk;

  filter_pair_arbiter #(.DATA_WIDTH(DW), .PARTICLE_ID_WIDTH(IW), .NUM_FILTER(NF)) dut (
    .clk                      (clk),
    .rst                      (rst),
    .filter_available         (filter_available),
    .filter_sel               (filter_sel),
    .filter_data              (filter_data),
    .out_ready                (out_ready),
    .out_valid                (out_valid),
    .ref_particle_id_out      (ref_id),
    .neighbor_particle_id_out (nbr_id),
    .r2                       (r2),
    .dx                       (dx),
    .dy                       (dy),
    .dz                       (dz)
`ifdef ARB_PERF_COUNTER_EN
    ,
    .pair_count               (pair_count),
    .stall_count              (stall_count)
`endif
  );

  typedef struct {logic [PW-1:0] rec; int cyc;} sb_t;
  sb_t           sb[$];
  logic [PW-1:0] fq[NF][$];

  int tests = 0, fails = 0, cyc = 0, ptr_m = 0, sel_cyc = 0, sel_count = 0;
  int pops = 0, stalls = 0, fill_pct = 100, ready_pct = 100;
  logic [NF-1:0] sel_seen = '0, fill_mask = '1;
  bit            prev_hold = 0, inj_pending = 0, inj_seen = 0;
  logic [PW-1:0] prev_out = '0, inj_rec = '0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [PW-1:0] mk(input logic [IW-1:0] rf, input logic [IW-1:0] nb,
                                       input logic [DW-1:0] a, input logic [DW-1:0] z,
                                       input logic [DW-1:0] y, input logic [DW-1:0] x);
    return {rf, nb, a, z, y, x};
  endfunction

  function automatic logic [PW-1:0] rnd_rec();
    return mk(IW'($urandom), IW'($urandom), $urandom, $urandom, $urandom, $urandom);
  endfunction

  // Filter buffers: a sel seen in cycle t pops the head and presents it in t+1.
  initial begin
    logic [PW-1:0] r;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (rst) begin
        for (int i = 0; i < NF; i++) begin
          if (sel_seen[i]) begin
            if (fq[i].size() == 0) begin
              tests++; fails++;
              $display("FAIL sel_empty: filter %0d selected with empty buffer", i);
            end else begin
              r = fq[i].pop_front();
              filter_data[i*PW +: PW] = r;
              sb.push_back('{r, sel_cyc});
            end
          end
        end
        if (inj_pending) begin
          fq[2].push_back(inj_rec);
          inj_pending = 0;
        end
        for (int i = 0; i < NF; i++)
          if (fill_mask[i] && fq[i].size() < 2 && $urandom_range(99) < fill_pct)
            fq[i].push_back(rnd_rec());
        for (int i = 0; i < NF; i++) filter_available[i] = (fq[i].size() != 0);
        out_ready = ($urandom_range(99) < ready_pct);
      end
    end
  end

  // Monitor: grant rule, output latency, handshake stability, record order.
  initial begin
    logic [NF-1:0] gexp;
    logic [PW-1:0] cur;
    sb_t           e;
    bit            vexp, popx, cani;
    int            j;
    forever begin
      @(negedge clk);
      if (!rst) begin
        sel_seen  = '0;
        prev_hold = 0;
      end else begin
        cur  = {ref_id, nbr_id, r2, dz, dy, dx};
        vexp = (sb.size() > 0) && (sb[0].cyc <= cyc - 2);
        chk("out_valid", out_valid, vexp);
        popx = vexp && out_ready;
        cani = (sb.size() - int'(popx)) <= 1;
        gexp = '0;
        if (cani) begin
          for (int k = 0; k < NF; k++) begin
            j = (ptr_m + k) % NF;
            if (filter_available[j] && gexp == '0) begin
              gexp[j] = 1'b1;
              ptr_m   = (j + 1) % NF;
            end
          end
        end
        chk("filter_sel", filter_sel, gexp);
        if (filter_available != '0 && !cani) stalls++;
        if (prev_hold) begin
          chk("hold_valid", out_valid, 1'b1);
          chk("hold_data", cur, prev_out);
        end
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            tests++; fails++;
            $display("FAIL pop_empty: output popped with nothing expected");
          end else begin
            e = sb.pop_front();
            chk("pair_data", cur, e.rec);
            if (e.rec == inj_rec && cur == inj_rec) inj_seen = 1;
          end
          pops++;
        end
        prev_hold = out_valid && !out_ready;
        prev_out  = cur;
        sel_seen  = filter_sel;
        sel_cyc   = cyc;
        if (filter_sel != '0) sel_count++;
      end
    end
  end

  task automatic do_reset();
    rst = 1'b0;
    sb.delete();
    ptr_m = 0; pops = 0; stalls = 0;
    for (int i = 0; i < NF; i++) begin
      fq[i].delete();
      fq[i].push_back(rnd_rec());
    end
    filter_available = '1;
    @(negedge clk);
    chk("rst_sel", filter_sel, '0);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_data", {ref_id, nbr_id, r2, dz, dy, dx}, '0);
    @(posedge clk);
    #2 rst = 1'b1;
  endtask

  initial begin
    int s;
    fill_mask = '1; fill_pct = 100; ready_pct = 100;
    do_reset();
    repeat (20) @(posedge clk);

    // Sparse requests, then none at all
    fill_mask = 4'b1010;
    repeat (10) @(posedge clk);
    fill_mask = 4'b0000;
    repeat (20) @(posedge clk);

    // Backpressure from an idle pipeline
    fill_mask = '1; ready_pct = 0;
    s = sel_count;
    repeat (10) @(posedge clk);
    chk("bp_sels", sel_count - s, 2);
    ready_pct = 100;
    repeat (10) @(posedge clk);

    // Single filter stream with a known record
    fill_mask = 4'b0100;
    inj_rec = mk(20'h00123, 20'h00456, 32'h42C80000, 32'h3F800000, 32'h40000000, 32'h40400000);
    inj_pending = 1;
    repeat (15) @(posedge clk);
    chk("inject_seen", inj_seen, 1'b1);

    // Random availability and backpressure
    fill_pct = 40; ready_pct = 60;
    for (int b = 0; b < 10; b++) begin
      fill_mask = NF'($urandom);
      repeat (100) @(posedge clk);
    end

    // Reset mid-operation, then resume
    fill_mask = '1; fill_pct = 100; ready_pct = 50;
    repeat (5) @(posedge clk);
    #2;
    do_reset();
    ready_pct = 100;
    repeat (30) @(posedge clk);

    // Drain: everything issued must come out
    fill_mask = '0; ready_pct = 100;
    repeat (30) @(posedge clk);
    @(negedge clk);
    chk("no_loss", sb.size(), 0);
`ifdef ARB_PERF_COUNTER_EN
    chk("pair_count", pair_count, pops);
    chk("stall_count", stall_count, stalls);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
